// File: rtl/demux_dispatch_8_if.sv
// -----------------------------------------------------------------------------
// demux_dispatch_8_if
// Bus bundle between the upstream word source, the dispatch buffer and the
// 1:8 demultiplexer it feeds.
//   in_valid/in_ready/in_data/in_dest : tagged valid/ready input stream
//   rr_mode                           : 1 = round-robin destination assignment
//   out_data/out_sel/out_valid        : pending word presented to the demux
//   out_ready/ch_busy                 : global accept and per-channel blocking
//   fifo_count                        : occupied buffer entries
// Modports: master = upstream/downstream environment, slave = dispatch block.
// -----------------------------------------------------------------------------
interface demux_dispatch_8_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_dest;
  logic              rr_mode;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_sel;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        ch_busy;
  logic [CW-1:0]     fifo_count;

  modport slave (
    input  in_valid, in_data, in_dest, rr_mode, out_ready, ch_busy,
    output in_ready, out_data, out_sel, out_valid, fifo_count
  );

  modport master (
    output in_valid, in_data, in_dest, rr_mode, out_ready, ch_busy,
    input  in_ready, out_data, out_sel, out_valid, fifo_count
  );
endinterface

// File: rtl/demux_dispatch_8.sv
// -----------------------------------------------------------------------------
// demux_dispatch_8
// Upstream feeder for a 16-bit 1:8 demultiplexer. Tagged words are buffered in
// a FIFO_DEPTH-entry FIFO; the head is moved into an output register and held
// there (data + 3-bit select) until the addressed channel accepts it.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        demux_dispatch_8_if.slave (input stream, output word, status)
//   sent_count 16-bit count of accepted output words (only with the macro)
// Optional feature macro: DEMUX_DISPATCH_COUNT_EN adds sent_count.
// -----------------------------------------------------------------------------
module demux_dispatch_8 #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_dispatch_8_if.slave    bus
`ifdef DEMUX_DISPATCH_COUNT_EN
  ,
  output logic [15:0]          sent_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 3;

  typedef enum logic {IDLE, SEND} state_t;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [2:0]        rr_ptr;
  state_t            state;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_sel;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              fire;
  logic [2:0]        dest;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Reset gates in_ready directly so nothing is taken while rst_n is low.
  assign bus.in_ready   = rst_n & ~full;
  assign bus.out_data   = out_data;
  assign bus.out_sel    = out_sel;
  assign bus.out_valid  = out_valid;
  assign bus.fifo_count = count;

  assign push = bus.in_valid & bus.in_ready;
  assign dest = bus.rr_mode ? rr_ptr : bus.in_dest;

  // Only the addressed channel's busy bit can stall the held word.
  assign fire = out_valid & bus.out_ready & ~bus.ch_busy[out_sel];

  // The output register refills when empty (IDLE) or when its word leaves.
  assign pop  = ~empty & ((state == IDLE) | fire);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the blocks are order-independent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (bus.rr_mode) rr_ptr <= rr_ptr + 3'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is defined solely by the
  // pointers and count, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_data, dest};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            {out_data, out_sel} <= mem[rd_ptr];
            out_valid           <= 1'b1;
            state               <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
            if (!empty) begin
              {out_data, out_sel} <= mem[rd_ptr];
            end else begin
              // Data/select keep their last value; only valid drops.
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_DISPATCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    sent_count <= '0;
    else if (fire) sent_count <= sent_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_demux_dispatch_8.sv
// -----------------------------------------------------------------------------
// tb_demux_dispatch_8
// Self-checking bench for demux_dispatch_8: a reset/transfer vector table,
// hand-written multi-cycle sequences and randomized traffic compared against
// a queue-based reference model of the buffer.
// -----------------------------------------------------------------------------
module tb_demux_dispatch_8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_dispatch_8_if #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

`ifdef DEMUX_DISPATCH_COUNT_EN
  logic [15:0] sent_count;
`endif

  demux_dispatch_8 #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef DEMUX_DISPATCH_COUNT_EN
    ,
    .sent_count (sent_count)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Every word in the block is either in m_q (buffer) or in the output slot.
  logic [DATA_W+2:0] m_q[$];
  bit                m_ov;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        m_sel;
  int                m_rr;
  int                m_sent;
  int                m_fires;

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit fire, push;
    logic [2:0] d;
    if (!rst_n) begin
      m_q.delete();
      m_ov = 0; m_data = '0; m_sel = '0; m_rr = 0; m_sent = 0; m_fires = 0;
      return;
    end
    fire = m_ov && bus.out_ready && !bus.ch_busy[m_sel];
    push = bus.in_valid && (m_q.size() < DEPTH);
    d    = bus.rr_mode ? 3'(m_rr) : bus.in_dest;
    if (fire) begin
      m_sent  = (m_sent + 1) % 65536;
      m_fires++;
    end
    if ((!m_ov || fire) && m_q.size() > 0) begin
      {m_data, m_sel} = m_q.pop_front();
      m_ov = 1;
    end else if (fire) begin
      m_ov = 0;
    end
    if (push) begin
      m_q.push_back({bus.in_data, d});
      if (bus.rr_mode) m_rr = (m_rr + 1) % 8;
    end
  endtask

  task automatic compare_all();
    check("out_valid",  32'(bus.out_valid),  32'(m_ov));
    check("out_data",   32'(bus.out_data),   32'(m_data));
    check("out_sel",    32'(bus.out_sel),    32'(m_sel));
    check("in_ready",   32'(bus.in_ready),   32'(rst_n && (m_q.size() < DEPTH)));
    check("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
`ifdef DEMUX_DISPATCH_COUNT_EN
    check("sent_count", 32'(sent_count),     32'(m_sent));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_data = '0; bus.in_dest = '0; bus.rr_mode = 0;
    bus.out_ready = 1; bus.ch_busy = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] data;
    logic [2:0]  dst;
    logic        rdy;
    logic [7:0]  busy;
    logic        e_ov;
    logic [15:0] e_data;
    logic [2:0]  e_sel;
    logic        e_ir;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vt[$];
  logic [2:0]  sel_seen[$];
  logic [15:0] dat_seen[$];

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_n = 0;

    // Reset, idle release, tagged transfer of 0xA5A5 to channel 5.
    vt.push_back('{0, 0, 16'h0000, 3'd0, 1, 8'h00, 0, 16'h0000, 3'd0, 0, 3'd0});
    vt.push_back('{0, 0, 16'h0000, 3'd0, 1, 8'h00, 0, 16'h0000, 3'd0, 0, 3'd0});
    vt.push_back('{1, 0, 16'h0000, 3'd0, 1, 8'h00, 0, 16'h0000, 3'd0, 1, 3'd0});
    vt.push_back('{1, 1, 16'hA5A5, 3'd5, 1, 8'h00, 0, 16'h0000, 3'd0, 1, 3'd1});
    vt.push_back('{1, 0, 16'h0000, 3'd0, 1, 8'h00, 1, 16'hA5A5, 3'd5, 1, 3'd0});
    vt.push_back('{1, 0, 16'h0000, 3'd0, 1, 8'h00, 0, 16'hA5A5, 3'd5, 1, 3'd0});
    vt.push_back('{1, 0, 16'h0000, 3'd0, 1, 8'hDF, 0, 16'hA5A5, 3'd5, 1, 3'd0});

    foreach (vt[i]) begin
      rst_n = vt[i].rst;
      bus.in_valid = vt[i].vld; bus.in_data = vt[i].data; bus.in_dest = vt[i].dst;
      bus.rr_mode = 0; bus.out_ready = vt[i].rdy; bus.ch_busy = vt[i].busy;
      model_edge();
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i),  32'(bus.out_valid),  32'(vt[i].e_ov));
      check($sformatf("vec%0d_out_data", i),   32'(bus.out_data),   32'(vt[i].e_data));
      check($sformatf("vec%0d_out_sel", i),    32'(bus.out_sel),    32'(vt[i].e_sel));
      check($sformatf("vec%0d_in_ready", i),   32'(bus.in_ready),   32'(vt[i].e_ir));
      check($sformatf("vec%0d_fifo_count", i), 32'(bus.fifo_count), 32'(vt[i].e_cnt));
    end

    // Round-robin wrap: 10 words tagged 7 must go to 0..7,0,1 without bubbles.
    idle_inputs();
    do_reset();
    begin
      int first, last;
      first = -1; last = -1;
      sel_seen.delete(); dat_seen.delete();
      for (int c = 0; c < 14; c++) begin
        bus.rr_mode  = 1;
        bus.in_dest  = 3'd7;
        bus.in_valid = (c < 10);
        bus.in_data  = 16'(c);
        step();
        if (bus.out_valid) begin
          sel_seen.push_back(bus.out_sel);
          dat_seen.push_back(bus.out_data);
          if (first < 0) first = c;
          last = c;
        end
      end
      check("rr_word_count", 32'(sel_seen.size()), 32'd10);
      check("rr_no_bubbles", 32'(last - first + 1), 32'd10);
      foreach (sel_seen[k]) begin
        check($sformatf("rr_sel%0d", k),  32'(sel_seen[k]), 32'(k % 8));
        check($sformatf("rr_data%0d", k), 32'(dat_seen[k]), 32'(k));
      end
    end

    // Channel backpressure: channel 3 blocked, buffer fills, then drains in order.
    idle_inputs();
    do_reset();
    bus.ch_busy = 8'h08;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1;
      bus.in_dest  = 3'd3;
      bus.in_data  = 16'h0300 + 16'(c);
      step();
    end
    bus.in_valid = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("bp_hold_data", 32'(bus.out_data), 32'h0300);
      check("bp_hold_sel",  32'(bus.out_sel),  32'd3);
    end
    check("bp_full_count", 32'(bus.fifo_count), 32'd4);
    check("bp_in_ready",   32'(bus.in_ready),   32'd0);
    bus.ch_busy = 8'h00;
    dat_seen.delete();
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) dat_seen.push_back(bus.out_data);
      step();
    end
    check("bp_drained", 32'(dat_seen.size()), 32'd5);
    foreach (dat_seen[k]) check($sformatf("bp_order%0d", k), 32'(dat_seen[k]), 32'h0300 + 32'(k));

    // Reset mid-operation: 3 buffered words plus one pending word are discarded.
    idle_inputs();
    do_reset();
    bus.ch_busy = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1;
      bus.in_dest  = 3'(c);
      bus.in_data  = 16'h0700 + 16'(c);
      step();
    end
    bus.in_valid = 0;
    check("mid_count_before", 32'(bus.fifo_count), 32'd3);
    check("mid_valid_before", 32'(bus.out_valid),  32'd1);
    rst_n = 0;
    step();
    check("mid_count_after", 32'(bus.fifo_count), 32'd0);
    check("mid_valid_after", 32'(bus.out_valid),  32'd0);
    rst_n = 1;
    bus.ch_busy = 8'h00;
    begin
      int reappear;
      reappear = 0;
      for (int c = 0; c < 6; c++) begin
        step();
        if (bus.out_valid) reappear++;
      end
      check("mid_no_reappear", 32'(reappear), 32'd0);
    end

    // Randomized traffic against the model.
    idle_inputs();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_n         = ($urandom_range(0, 79) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 16'($urandom);
      bus.in_dest   = 3'($urandom);
      if ($urandom_range(0, 15) == 0) bus.rr_mode = ~bus.rr_mode;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.ch_busy   = 8'(1 << $urandom_range(0, 7)) & {8{$urandom_range(0, 2) == 0}};
      step();
    end
    rst_n = 1;

`ifdef DEMUX_DISPATCH_COUNT_EN
    // Counter wrap: 0x10000 fires return it to 0, three more give 3.
    idle_inputs();
    do_reset();
    bus.in_valid = 1;
    for (int c = 0; c < 70000 && m_fires < 65536; c++) begin
      bus.in_data = 16'(c);
      step();
    end
    check("cnt_wrap", 32'(sent_count), 32'h0000);
    for (int c = 0; c < 10 && m_fires < 65539; c++) step();
    check("cnt_plus3", 32'(sent_count), 32'h0003);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
